run_detector: RTL and testbench

- Parametrised successor to the lab 5 fixed 0000/1111 detector.
- Detects RUN_LEN consecutive identical symbols on a SYM_W-bit input stream, with a valid qualifier.
- Overlap / non-overlap mode is selectable by parameter, and a saturating detection counter is included.
- Sits between switch/debounce input logic and LED/HEX display logic; z and the counter drive the board outputs.

---
 rtl/run_det_pkg.sv | 42 ++++
 rtl/run_detector_if.sv | 42 ++++
 rtl/sat_counter.sv | 37 +++
 rtl/run_detector.sv | 151 +++++++++++++++
 tb/tb_run_detector.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/run_det_pkg.sv
// -----------------------------------------------------------------------------
// run_det_pkg
// Shared definitions for the run detector:
//   - one-hot internal FSM state type and the 2-bit encoding shown on the
//     debug state port (IDLE=0, RUN=1, HIT=2)
//   - legal RUN_LEN range and an elaboration-time range-check helper
//   - one-hot to encoded state conversion
// -----------------------------------------------------------------------------
package run_det_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ENC_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ENC_HIT  = 2'd2;

  localparam int RUN_LEN_MIN = 2;
  localparam int RUN_LEN_MAX = 255;

  // One-hot internal state; a corrupted (non one-hot) value falls back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_HIT  = 3'b100
  } state_e;

  function automatic bit run_len_ok(input int n);
    return (n >= RUN_LEN_MIN) && (n <= RUN_LEN_MAX);
  endfunction

  function automatic logic [STATE_W-1:0] encode_state(input state_e s);
    logic [STATE_W-1:0] e;
    case (s)
      ST_IDLE: e = ENC_IDLE;
      ST_RUN:  e = ENC_RUN;
      ST_HIT:  e = ENC_HIT;
      default: e = ENC_IDLE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// -----------------------------------------------------------------------------
// run_detector_if
// Symbol stream and status bundle of the run detector.
//   in_valid : qualifies w (sample accepted on a rising edge with in_valid=1)
//   w        : input symbol, SYM_W bits
//   clr_cnt  : synchronous clear of det_cnt
//   z        : Moore detect flag
//   z_sym    : symbol of the detected run (0 when z=0)
//   run_cnt  : current run length, saturating at RUN_LEN
//   det_cnt  : saturating hit counter
//   state    : encoded FSM state for debug LEDs
// master = stimulus side, slave = detector side.
// -----------------------------------------------------------------------------
interface run_detector_if #(
  parameter int SYM_W   = 1,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
);
  import run_det_pkg::*;

  localparam int RC_W = $clog2(RUN_LEN + 1);

  logic               in_valid;
  logic [SYM_W-1:0]   w;
  logic               clr_cnt;
  logic               z;
  logic [SYM_W-1:0]   z_sym;
  logic [RC_W-1:0]    run_cnt;
  logic [CNT_W-1:0]   det_cnt;
  logic [STATE_W-1:0] state;

  modport master (
    output in_valid, w, clr_cnt,
    input  z, z_sym, run_cnt, det_cnt, state
  );

  modport slave (
    input  in_valid, w, clr_cnt,
    output z, z_sym, run_cnt, det_cnt, state
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones. Clear has priority over increment.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset (q -> 0)
//   inc    : count one event this edge
//   clr    : synchronous clear
//   q      : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_ZERO = {W{1'b0}};
  localparam logic [W-1:0] Q_FULL = {W{1'b1}};
  localparam logic [W-1:0] Q_ONE  = W'(1);

  // Count register: clear beats increment, increment stops at all-ones.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= Q_ZERO;
    end else if (clr) begin
      q <= Q_ZERO;
    end else if (inc && (q != Q_FULL)) begin
      q <= q + Q_ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/run_detector.sv
// -----------------------------------------------------------------------------
// run_detector
// Detects RUN_LEN consecutive identical SYM_W-bit symbols on a qualified
// stream. In overlap mode every further matching sample after a hit is a new
// hit; in non-overlap mode a hit consumes its samples and the count restarts.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : run_detector_if.slave (in_valid, w, clr_cnt in;
//            z, z_sym, run_cnt, det_cnt, state out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int SYM_W   = 1,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic         clock,
  input  logic         resetn,
  run_detector_if.slave bus
);

  localparam int RC_W = $clog2(RUN_LEN + 1);
  localparam logic [RC_W-1:0]  RC_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  RUN_MAX  = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0]  RUN_LM1  = RC_W'(RUN_LEN - 1);
  localparam logic [SYM_W-1:0] SYM_ZERO = {SYM_W{1'b0}};

  // Reject an illegal RUN_LEN while elaborating.
  generate
    if (!run_len_ok(RUN_LEN)) begin : g_bad_run_len
      $error("run_detector: RUN_LEN=%0d outside legal range 2..255", RUN_LEN);
    end
  endgenerate

  state_e             state_r, state_s;
  logic [RC_W-1:0]    run_cnt_r, run_cnt_s;
  logic [SYM_W-1:0]   last_sym_r, last_sym_s;
  logic               z_r, z_s;
  logic [SYM_W-1:0]   z_sym_r, z_sym_s;
  logic [STATE_W-1:0] state_enc_r, state_enc_s;
  logic               hit_s;
  logic [CNT_W-1:0]   det_cnt_s;

  // Next state, run length and remembered symbol for an accepted sample.
  always_comb begin
    state_s    = state_r;
    run_cnt_s  = run_cnt_r;
    last_sym_s = last_sym_r;
    hit_s      = 1'b0;
    if (bus.in_valid) begin
      case (state_r)
        ST_IDLE: begin
          state_s    = ST_RUN;
          run_cnt_s  = RC_ONE;
          last_sym_s = bus.w;
        end
        ST_RUN: begin
          if (bus.w != last_sym_r) begin
            state_s    = ST_RUN;
            run_cnt_s  = RC_ONE;
            last_sym_s = bus.w;
          end else if (run_cnt_r == RUN_LM1) begin
            state_s   = ST_HIT;
            run_cnt_s = RUN_MAX;
            hit_s     = 1'b1;
          end else begin
            state_s   = ST_RUN;
            run_cnt_s = run_cnt_r + RC_ONE;
          end
        end
        ST_HIT: begin
          if (bus.w != last_sym_r) begin
            state_s    = ST_RUN;
            run_cnt_s  = RC_ONE;
            last_sym_s = bus.w;
          end else if (OVERLAP != 0) begin
            // Window slides by one: the run stays long enough, hit again.
            state_s   = ST_HIT;
            run_cnt_s = RUN_MAX;
            hit_s     = 1'b1;
          end else begin
            // The previous hit used up its samples; this one starts afresh.
            state_s   = ST_RUN;
            run_cnt_s = RC_ONE;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          run_cnt_s  = RC_ZERO;
          last_sym_s = SYM_ZERO;
        end
      endcase
    end else begin
      state_s    = state_r;
      run_cnt_s  = run_cnt_r;
      last_sym_s = last_sym_r;
    end
  end

  // Output values computed from the next state so they can be registered.
  always_comb begin
    z_s         = (state_s == ST_HIT);
    state_enc_s = encode_state(state_s);
    if (z_s) begin
      z_sym_s = last_sym_s;
    end else begin
      z_sym_s = SYM_ZERO;
    end
  end

  // FSM, run length and registered status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      run_cnt_r   <= RC_ZERO;
      last_sym_r  <= SYM_ZERO;
      z_r         <= 1'b0;
      z_sym_r     <= SYM_ZERO;
      state_enc_r <= ENC_IDLE;
    end else begin
      state_r     <= state_s;
      run_cnt_r   <= run_cnt_s;
      last_sym_r  <= last_sym_s;
      z_r         <= z_s;
      z_sym_r     <= z_sym_s;
      state_enc_r <= state_enc_s;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_det_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (hit_s),
    .clr    (bus.clr_cnt),
    .q      (det_cnt_s)
  );

  assign bus.z       = z_r;
  assign bus.z_sym   = z_sym_r;
  assign bus.run_cnt = run_cnt_r;
  assign bus.det_cnt = det_cnt_s;
  assign bus.state   = state_enc_r;

endmodule

// File: tb/tb_run_detector.sv
// -----------------------------------------------------------------------------
// tb_run_detector
// Three detector configurations share one stimulus stream:
//   u0: RUN_LEN=4, SYM_W=1, OVERLAP=1, CNT_W=8
//   u1: RUN_LEN=4, SYM_W=1, OVERLAP=0, CNT_W=8
//   u2: RUN_LEN=3, SYM_W=2, OVERLAP=1, CNT_W=2
// The reference model tracks the length L of the trailing run of identical
// accepted symbols and derives every output from L arithmetically.
// -----------------------------------------------------------------------------
module tb_run_detector;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [1:0] w_drv;
  logic       clr_cnt;

  always #5 clock = ~clock;

  run_detector_if #(.SYM_W(1), .RUN_LEN(4), .CNT_W(8)) if0 ();
  run_detector_if #(.SYM_W(1), .RUN_LEN(4), .CNT_W(8)) if1 ();
  run_detector_if #(.SYM_W(2), .RUN_LEN(3), .CNT_W(2)) if2 ();

  assign if0.in_valid = in_valid;
  assign if0.w        = w_drv[0];
  assign if0.clr_cnt  = clr_cnt;
  assign if1.in_valid = in_valid;
  assign if1.w        = w_drv[0];
  assign if1.clr_cnt  = clr_cnt;
  assign if2.in_valid = in_valid;
  assign if2.w        = w_drv;
  assign if2.clr_cnt  = clr_cnt;

  run_detector #(.RUN_LEN(4), .SYM_W(1), .OVERLAP(1), .CNT_W(8)) u0 (
    .clock (clock), .resetn (resetn), .bus (if0));
  run_detector #(.RUN_LEN(4), .SYM_W(1), .OVERLAP(0), .CNT_W(8)) u1 (
    .clock (clock), .resetn (resetn), .bus (if1));
  run_detector #(.RUN_LEN(3), .SYM_W(2), .OVERLAP(1), .CNT_W(2)) u2 (
    .clock (clock), .resetn (resetn), .bus (if2));

  // Observed outputs, zero-extended to common widths.
  logic [2:0] o_z;
  logic [1:0] o_zs [3];
  logic [2:0] o_rc [3];
  logic [7:0] o_dc [3];
  logic [1:0] o_st [3];

  assign o_z[0]  = if0.z;
  assign o_zs[0] = {1'b0, if0.z_sym};
  assign o_rc[0] = if0.run_cnt;
  assign o_dc[0] = if0.det_cnt;
  assign o_st[0] = if0.state;
  assign o_z[1]  = if1.z;
  assign o_zs[1] = {1'b0, if1.z_sym};
  assign o_rc[1] = if1.run_cnt;
  assign o_dc[1] = if1.det_cnt;
  assign o_st[1] = if1.state;
  assign o_z[2]  = if2.z;
  assign o_zs[2] = if2.z_sym;
  assign o_rc[2] = {1'b0, if2.run_cnt};
  assign o_dc[2] = {6'b0, if2.det_cnt};
  assign o_st[2] = if2.state;

  // Per-configuration parameters as seen by the model.
  int p_rl   [3] = '{4, 4, 3};
  int p_ovl  [3] = '{1, 0, 1};
  int p_mask [3] = '{1, 1, 3};
  int p_max  [3] = '{255, 255, 3};

  // Model state: trailing run length (0 = nothing accepted since reset),
  // symbol of that run, and hit count.
  int m_len  [3];
  int m_last [3];
  int m_dc   [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_z(input int i);
    if (m_len[i] == 0) return 0;
    if (p_ovl[i] != 0) return (m_len[i] >= p_rl[i]) ? 1 : 0;
    return ((m_len[i] % p_rl[i]) == 0) ? 1 : 0;
  endfunction

  function automatic int exp_rc(input int i);
    if (m_len[i] == 0) return 0;
    if (p_ovl[i] != 0) return (m_len[i] < p_rl[i]) ? m_len[i] : p_rl[i];
    return ((m_len[i] - 1) % p_rl[i]) + 1;
  endfunction

  function automatic int exp_st(input int i);
    if (m_len[i] == 0) return 0;
    return (exp_z(i) != 0) ? 2 : 1;
  endfunction

  function automatic int exp_zs(input int i);
    return (exp_z(i) != 0) ? m_last[i] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_len[i]  = 0;
      m_last[i] = 0;
      m_dc[i]   = 0;
    end
  endtask

  task automatic model_edge(input bit v, input int s, input bit clr);
    for (int i = 0; i < 3; i++) begin
      int sym;
      int hit;
      hit = 0;
      sym = s & p_mask[i];
      if (v) begin
        if (m_len[i] == 0 || sym != m_last[i]) m_len[i] = 1;
        else m_len[i] = m_len[i] + 1;
        m_last[i] = sym;
        hit = exp_z(i);
      end
      if (clr) m_dc[i] = 0;
      else if (hit != 0 && m_dc[i] < p_max[i]) m_dc[i] = m_dc[i] + 1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d.z", i),       int'(o_z[i]),  exp_z(i));
      check_eq($sformatf("u%0d.z_sym", i),   int'(o_zs[i]), exp_zs(i));
      check_eq($sformatf("u%0d.run_cnt", i), int'(o_rc[i]), exp_rc(i));
      check_eq($sformatf("u%0d.det_cnt", i), int'(o_dc[i]), m_dc[i]);
      check_eq($sformatf("u%0d.state", i),   int'(o_st[i]), exp_st(i));
    end
  endtask

  // Drive one cycle of stimulus, advance the model on the edge, then compare.
  task automatic step(input bit v, input int s, input bit clr);
    in_valid = v;
    w_drv    = 2'(s);
    clr_cnt  = clr;
    @(posedge clock);
    model_edge(v, s, clr);
    #1;
    check_all();
  endtask

  // Assert reset between edges, check the immediate effect, hold it across
  // one edge, then release away from the edge.
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    bit v;
    bit clr;
    int s;
    int prev;

    resetn   = 1'b0;
    in_valid = 1'b0;
    w_drv    = 2'd0;
    clr_cnt  = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clock);
    #3;
    resetn = 1'b1;

    // Five matching ones.
    for (int k = 0; k < 5; k++) step(1'b1, 1, 1'b0);
    check_eq("plan_a.det_cnt", int'(o_dc[0]), 2);
    check_eq("plan_a.z_sym", int'(o_zs[0]), 1);

    // Reset arrives while u0 sits in HIT.
    async_reset();

    // Eight zeros: non-overlap hits only on the 4th and 8th.
    for (int k = 0; k < 8; k++) step(1'b1, 0, 1'b0);
    check_eq("plan_b.det_cnt", int'(o_dc[1]), 2);

    // Zeros then ones: the run restarts on the first one.
    async_reset();
    for (int k = 0; k < 7; k++) begin
      step(1'b1, (k < 3) ? 0 : 1, 1'b0);
      if (k == 3) check_eq("plan_c.run_cnt", int'(o_rc[0]), 1);
    end
    check_eq("plan_c.z", int'(o_z[0]), 1);

    // Gaps in in_valid do not break a run (u2, 2-bit symbol 2).
    async_reset();
    step(1'b1, 2, 1'b0);
    step(1'b1, 2, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1, 1'b0);
    step(1'b1, 2, 1'b0);
    check_eq("plan_d.z", int'(o_z[2]), 1);
    check_eq("plan_d.z_sym", int'(o_zs[2]), 2);

    // Saturate u2's 2-bit counter, then clear on a hit edge.
    for (int k = 0; k < 6; k++) step(1'b1, 2, 1'b0);
    check_eq("plan_e.sat", int'(o_dc[2]), 3);
    step(1'b1, 2, 1'b1);
    check_eq("plan_e.clr_det", int'(o_dc[2]), 0);
    check_eq("plan_e.clr_z", int'(o_z[2]), 1);

    // Reset in HIT, then a fresh run is needed.
    async_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 3, 1'b0);

    // Randomised traffic with sticky symbols so runs are common.
    prev = 0;
    for (int k = 0; k < 1500; k++) begin
      v   = ($urandom_range(0, 9) < 8);
      s   = ($urandom_range(0, 9) < 7) ? prev : int'($urandom_range(0, 3));
      clr = ($urandom_range(0, 49) == 0);
      prev = s;
      step(v, s, clr);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
